perf_cnt_reporter: RTL
======================

Name: perf_cnt_reporter

Overview:
- Parametrised cache/performance event counter bank with an ASCII-hex serializer. Successor to the fixed 8-event, 12-bit counter block.
- Counts rising edges on NUM_CH event lines and snapshots all counters on a CPU request or a periodic timer.
- Streams the snapshot as an ASCII frame to the UART TX through a valid/ready byte handshake.
- Sits between the cache hierarchy event strobes and the UART tx module.

Parameters:
- NUM_CH, 8: number of event channels (1..26); channel tags are 'a'..'z'.
- CNT_W, 12: counter width in bits (4..32).
- PERIOD, 0: periodic snapshot interval in clk cycles; 0 disables the periodic trigger.
- CLEAR_ON_SNAP, 0: 1 means live counters restart from 0 on each accepted snapshot.
- SATURATE, 1: 1 means counters stick at all-ones; 0 means they wrap.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: asynchronous active-low reset.
- evt_i, in, NUM_CH: event strobes, level signals; each rising edge counts once.
- snap_req, in, 1: CPU snapshot request; its rising edge triggers a snapshot.
- tx_ready, in, 1: UART TX can accept a byte.
- data_o, out, 8: ASCII byte to the UART.
- valid_o, out, 1: data_o is valid.
- busy_o, out, 1: a frame is in progress.
- overrun_o, out, 1: sticky flag, set when a trigger is dropped.

Behaviour:
- Reset (asynchronous, rstn=0):
  - All counters, shadows, edge registers, the timer and the FSM go to 0 / IDLE.
  - data_o=0, valid_o=0, busy_o=0, overrun_o=0.
  - Reset asserted mid-frame aborts the frame immediately; no partial completion.
- Edge detect:
  - evt_prev[i] <= evt_i[i] every cycle.
  - Increment condition: evt_i[i] & ~evt_prev[i].
  - A level held high counts once.
- Counter width:
  - At all-ones, SATURATE=1 holds the value; SATURATE=0 wraps to 0.
- Periodic timer:
  - Free-running 0..PERIOD-1.
  - Raises a trigger in the cycle it equals PERIOD-1, then wraps to 0.
- Trigger:
  - trig = (snap_req & ~snap_prev) | timer trigger.
  - Simultaneous CPU and timer triggers count as one trigger.
- Snapshot:
  - Accepted only in IDLE. Shadows capture the live counter values on that edge.
  - With CLEAR_ON_SNAP=1 the live counters load 0 on the same edge.
  - If an event edge lands in that same cycle, the live counter loads 1; the event is not lost and not included in the shadow.
- Trigger while busy: dropped, overrun_o set. overrun_o clears only on reset.
- FSM states: IDLE, TAG, DIGIT, CR, LF.
  - IDLE -> TAG on an accepted trigger; ch=0, dig=0.
  - TAG: byte = 8'h61 + ch; next state DIGIT.
  - DIGIT: D = ceil(CNT_W/4) digits per channel, most-significant nibble first; nibble index D-1-dig.
    - The top nibble is zero-padded when CNT_W%4 != 0.
    - After the last digit: go to TAG with ch+1, or to CR if ch == NUM_CH-1.
  - CR: byte 8'h0D; next state LF.
  - LF: byte 8'h0A; next state IDLE.
  - The FSM advances only on a cycle where valid_o & tx_ready.
- Hex encoding: nibble 0-9 -> 8'h30+n; nibble 10-15 -> 8'h41+(n-10), i.e. 'A'..'F'.
- Output handshake:
  - valid_o=1 in every non-IDLE state; busy_o = (state != IDLE).
  - data_o is registered and held stable while valid_o & ~tx_ready.
  - The next byte appears the cycle after acceptance, so tx_ready tied high gives one byte per cycle.
- Latency: trigger accepted at edge k -> valid_o=1 with the tag 'a' from cycle k+1.
- Frame length: NUM_CH*(1+D)+2 bytes; the default is 34.
- Counting continues uninterrupted during serialization.

Decomposition:
- Package perf_cnt_pkg:
  - ASCII constants: TAG_BASE 8'h61, CR 8'h0D, LF 8'h0A, '0' 8'h30, 'A' 8'h41.
  - FSM state enum.
  - Function nib2ascii.
  - Function ndig(CNT_W) = (CNT_W+3)/4.
- Sub-module perf_evt_cnt, one per channel (generate loop): edge detect, saturating/wrapping counter, clear-with-coincident-event rule.
- The top level holds the timer, shadows and serializer FSM.

Test Plan:
- Default params, 3 pulses on evt_i[0], 5 on evt_i[2], snap_req pulse, tx_ready=1 -> frame "a003b000c005d000…h000\r\n", 34 bytes, valid_o continuous, busy_o falls after LF.
- tx_ready toggling 1-of-4 cycles -> identical byte sequence; data_o stable while stalled; no duplicated or skipped bytes.
- CNT_W=4, SATURATE=1, 20 pulses on ch0 -> "aF…"; SATURATE=0 -> "a4".
- CLEAR_ON_SNAP=1, 2 pulses, then a snapshot with a coincident edge on ch0 -> frame "a002"; next snapshot with no further events -> "a001".
- PERIOD=100, CPU snap_req asserted during the frame -> overrun_o=1, no second frame until busy_o=0; the periodic trigger after that produces a fresh frame.
- rstn low at byte 10 of a frame -> asynchronous return to IDLE: valid_o=0, counters 0, overrun_o=0; the next snapshot shows all zeros.

Source files
------------

// File: rtl/perf_cnt_pkg.sv
// Shared constants, FSM state encoding and helpers for the perf counter reporter.
package perf_cnt_pkg;

    localparam logic [7:0] TAG_BASE    = 8'h61;
    localparam logic [7:0] CR          = 8'h0D;
    localparam logic [7:0] LF          = 8'h0A;
    localparam logic [7:0] ASC_ZERO    = 8'h30;
    localparam logic [7:0] ASC_UPPER_A = 8'h41;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_DIGIT,
        S_CR,
        S_LF
    } state_e;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (ASC_ZERO + 8'(n)) : (ASC_UPPER_A + 8'(n - 4'd10));
    endfunction

    function automatic int unsigned ndig(input int unsigned w);
        return (w + 3) / 4;
    endfunction

endpackage

// File: rtl/perf_evt_cnt.sv
// One event channel: rising-edge detect feeding a saturating or wrapping counter.
module perf_evt_cnt
    import perf_cnt_pkg::*;
#(
    parameter int unsigned CNT_W    = 12,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             evt_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic             evt_prev_q, evt_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc;

    // A clear coinciding with an edge keeps that edge in the live count.
    always_comb begin
        evt_prev_d = evt_i;
        inc        = evt_i & ~evt_prev_q;
        cnt_d      = cnt_q;
        if (clr_i) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            if (&cnt_q) begin
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            evt_prev_q <= evt_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_cnt_reporter.sv
// Event counter bank with snapshot shadows and an ASCII-hex frame serializer
// ("a<hex>b<hex>...\r\n") feeding a valid/ready byte sink.
module perf_cnt_reporter
    import perf_cnt_pkg::*;
#(
    parameter int unsigned NUM_CH        = 8,
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned PERIOD        = 0,
    parameter bit          CLEAR_ON_SNAP = 1'b0,
    parameter bit          SATURATE      = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] evt_i,
    input  logic              snap_req,
    input  logic              tx_ready,
    output logic [7:0]        data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int unsigned D     = ndig(CNT_W);
    localparam int unsigned PAD_W = 4 * D;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DIG_W = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt      [NUM_CH];
    logic [CNT_W-1:0] shadow_q [NUM_CH];
    logic [CNT_W-1:0] shadow_d [NUM_CH];

    state_e           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             snap_prev_q, snap_prev_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             timer_trig, trig, accept, clr_c, adv;
    logic [PAD_W-1:0] cur_pad;
    logic [DIG_W-1:0] nib_idx;
    logic [3:0]       nib;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        perf_evt_cnt #(
            .CNT_W   (CNT_W),
            .SATURATE(SATURATE)
        ) u_cnt (
            .clk  (clk),
            .rstn (rstn),
            .evt_i(evt_i[g]),
            .clr_i(clr_c),
            .cnt_o(cnt[g])
        );
    end

    // Trigger, shadow capture and overrun tracking.
    always_comb begin
        timer_trig  = (PERIOD != 0) && (timer_q == TMR_W'(PERIOD - 1));
        timer_d     = (PERIOD == 0 || timer_trig) ? '0 : timer_q + TMR_W'(1);
        snap_prev_d = snap_req;
        trig        = (snap_req & ~snap_prev_q) | timer_trig;
        accept      = trig & (state_q == S_IDLE);
        overrun_d   = overrun_q | (trig & (state_q != S_IDLE));
        clr_c       = accept & CLEAR_ON_SNAP;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            shadow_d[k] = accept ? cnt[k] : shadow_q[k];
        end
    end

    // Serializer: next state, then the byte that state will present.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dig_d   = dig_q;
        adv     = valid_q & tx_ready;
        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d = S_TAG;
                ch_d    = '0;
                dig_d   = '0;
            end
        end else if (adv) begin
            case (state_q)
                S_TAG: begin
                    state_d = S_DIGIT;
                    dig_d   = '0;
                end
                S_DIGIT: begin
                    if (dig_q == DIG_W'(D - 1)) begin
                        dig_d = '0;
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            state_d = S_CR;
                        end else begin
                            state_d = S_TAG;
                            ch_d    = ch_q + CH_W'(1);
                        end
                    end else begin
                        dig_d = dig_q + DIG_W'(1);
                    end
                end
                S_CR:    state_d = S_LF;
                S_LF:    state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        cur_pad = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_d == CH_W'(k)) cur_pad = PAD_W'(shadow_q[k]);
        end
        nib_idx = DIG_W'(D - 1) - dig_d;
        nib     = '0;
        for (int unsigned k = 0; k < D; k++) begin
            if (nib_idx == DIG_W'(k)) nib = cur_pad[4*k +: 4];
        end

        case (state_d)
            S_TAG:   data_d = TAG_BASE + 8'(ch_d);
            S_DIGIT: data_d = nib2ascii(nib);
            S_CR:    data_d = CR;
            S_LF:    data_d = LF;
            default: data_d = 8'h00;
        endcase
        valid_d = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            dig_q       <= '0;
            timer_q     <= '0;
            snap_prev_q <= 1'b0;
            overrun_q   <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            dig_q       <= dig_d;
            timer_q     <= timer_d;
            snap_prev_q <= snap_prev_d;
            overrun_q   <= overrun_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            for (int unsigned k = 0; k < NUM_CH; k++) shadow_q[k] <= shadow_d[k];
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule
